alu16_nibble_seq: RTL



---
 rtl/alu16_nibble_seq_pkg.sv | 18 +
 rtl/alu16_nibble_seq_if.sv | 29 ++
 rtl/module_ula_74181.sv | 25 ++
 rtl/alu16_nibble_seq.sv | 127 ++++++++++++
 4 files changed

// File: rtl/alu16_nibble_seq_pkg.sv
// Shared types and 74181 function-select encodings for the nibble-serial ALU.
package alu16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Arithmetic selects assume m=0; subtraction also needs cin=1.
    localparam logic [3:0] FN_ADD = 4'b1001;
    localparam logic [3:0] FN_SUB = 4'b0110;
    // Logic selects assume m=1.
    localparam logic [3:0] FN_XOR = 4'b0110;
    localparam logic [3:0] FN_AND = 4'b1011;
    localparam logic [3:0] FN_OR  = 4'b1110;

endpackage

// File: rtl/alu16_nibble_seq_if.sv
// Request/response channel of the nibble-serial ALU; NIBBLES must match the attached block.
interface alu16_nibble_seq_if #(parameter int NIBBLES = 4);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [3:0]   in_s;
    logic         in_m;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_f;
    logic         out_cout;
    logic         out_eq;
    logic         busy;

    modport master (
        output in_valid, in_a, in_b, in_s, in_m, in_cin, out_ready,
        input  in_ready, out_valid, out_f, out_cout, out_eq, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_s, in_m, in_cin, out_ready,
        output in_ready, out_valid, out_f, out_cout, out_eq, busy
    );

endinterface

// File: rtl/module_ula_74181.sv
// Functional model of one 74181 4-bit ALU slice, active-high data and active-high carry.
module module_ula_74181 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [3:0] f,
    output logic       c_out,
    output logic       a_eq_b
);
    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] sum;

    // Every 74181 function is X plus Y plus carry, or the XNOR of X and Y in logic mode.
    assign x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    assign y   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    assign sum = {1'b0, x} + {1'b0, y} + {4'b0000, c_in};

    assign f      = m ? ~(x ^ y) : sum[3:0];
    assign c_out  = sum[4];
    assign a_eq_b = &f;

endmodule

// File: rtl/alu16_nibble_seq.sv
// Multi-cycle ALU: one 74181 slice walks the operands LSB nibble first, carry rippling through a register.
import alu16_pkg::*;

module alu16_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu16_nibble_seq_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  res_q;
    logic [W-1:0]  res_nxt;
    logic [W-1:0]  f_q;
    logic [3:0]    s_q;
    logic          m_q;
    logic          carry_q;
    logic          eq_q;
    logic          cout_q;
    logic          eqo_q;
    logic [IW-1:0] idx_q;
    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [3:0]    nib_f;
    logic          nib_cout;
    logic          nib_eq;

    assign nib_a = a_q[{idx_q, 2'b00} +: 4];
    assign nib_b = b_q[{idx_q, 2'b00} +: 4];

    module_ula_74181 alu (
        .a      (nib_a),
        .b      (nib_b),
        .s      (s_q),
        .m      (m_q),
        .c_in   (carry_q),
        .f      (nib_f),
        .c_out  (nib_cout),
        .a_eq_b (nib_eq)
    );

    always_comb begin
        res_nxt = res_q;
        res_nxt[{idx_q, 2'b00} +: 4] = nib_f;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (idx_q == LAST) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response fields live in their own registers so they hold steady while the next op ripples.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            eq_q    <= 1'b1;
            res_q   <= '0;
            f_q     <= '0;
            cout_q  <= 1'b0;
            eqo_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.in_a;
                        b_q     <= bus.in_b;
                        s_q     <= bus.in_s;
                        m_q     <= bus.in_m;
                        carry_q <= bus.in_cin;
                        eq_q    <= 1'b1;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    res_q   <= res_nxt;
                    carry_q <= nib_cout;
                    eq_q    <= eq_q & nib_eq;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        f_q    <= res_nxt;
                        cout_q <= ~m_q & nib_cout;
                        eqo_q  <= eq_q & nib_eq;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_f    = f_q;
    assign bus.out_cout = cout_q;
    assign bus.out_eq   = eqo_q;
    assign bus.busy     = (state != IDLE);

endmodule
